// File: rtl/prod3_pkg.sv
// prod3_pkg: shared types and constants for the program-3 product sequencer.
//   state_t      : sequencer FSM states
//   MUL_STEPS    : cycles per serial multiply (one multiplier bit per cycle)
//   DEF_IN_BASE  : default data-memory address of operand A
//   DEF_OUT_BASE : default data-memory address of the product LSB
package prod3_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LD_A,
      LD_B,
      LD_C,
      MUL1,
      MUL2,
      SIGN,
      ST0,
      ST1,
      ST2,
      DONE
   } state_t;

   localparam int MUL_STEPS    = 8;
   localparam int DEF_IN_BASE  = 0;
   localparam int DEF_OUT_BASE = 3;

endpackage

// File: rtl/prod3_sequencer_serial_umul.sv
// serial_umul: iterative unsigned shift-add multiplier, one multiplier bit
// per cycle, LSB first. The product is truncated to MW bits.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture operands and perform the first step in the same cycle
//   step       : perform one further shift-add step (valid while busy)
//   mcand      : multiplicand (MW bits)
//   mplier     : multiplier (NW bits)
//   busy       : steps still outstanding after a load
//   prod       : accumulated product
module serial_umul #(
   parameter int MW    = 24,
   parameter int NW    = 9,
   parameter int STEPS = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          step,
   input  logic [MW-1:0] mcand,
   input  logic [NW-1:0] mplier,
   output logic          busy,
   output logic [MW-1:0] prod
);

   localparam int CW = $clog2(STEPS);

   logic [MW-1:0] mc_q;
   logic [NW-1:0] mp_q;
   logic [CW-1:0] cnt_q;

   assign busy = (cnt_q != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         prod  <= '0;
         mc_q  <= '0;
         mp_q  <= '0;
         cnt_q <= '0;
      end else if (load) begin
         // the load cycle already consumes multiplier bit 0
         prod  <= mplier[0] ? mcand : '0;
         mc_q  <= mcand << 1;
         mp_q  <= mplier >> 1;
         cnt_q <= CW'(STEPS - 1);
      end else if (step && busy) begin
         if (mp_q[0]) begin
            prod <= prod + mc_q;
         end
         mc_q  <= mc_q << 1;
         mp_q  <= mp_q >> 1;
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/prod3_sequencer.sv
// prod3_sequencer: computes D = OpA * OpB * OpC on 8-bit two's-complement
// operands read from dm[IN_BASE..IN_BASE+2]; writes the 24-bit product
// little-endian to dm[OUT_BASE..OUT_BASE+2]. A falling edge of start
// launches a run; done stays high until start rises again.
//   clk, reset  : clock, synchronous active-high reset
//   start       : request (falling edge starts a run)
//   done        : result valid
//   mem_addr    : data-memory address
//   mem_wr_en   : data-memory write strobe
//   mem_wr_data : data-memory write data
//   mem_rd_data : data-memory read data (combinational from mem_addr)
// Build option: define PROD3_ZERO_SKIP_EN to jump straight to the store
// phase with a zero product when any operand is zero.
module prod3_sequencer import prod3_pkg::*; #(
   parameter int DW       = 8,
   parameter int PW       = 24,
   parameter int AW       = 8,
   parameter int IN_BASE  = DEF_IN_BASE,
   parameter int OUT_BASE = DEF_OUT_BASE
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_wr_en,
   output logic [DW-1:0] mem_wr_data,
   input  logic [DW-1:0] mem_rd_data
);

   localparam int CW = $clog2(MUL_STEPS);

   state_t        state, next;
   logic          start_q;
   logic [CW-1:0] cnt;

   logic [DW:0]   mag_a, mag_b, mag_c;
   logic          s_a, s_b, s_c;
   logic [PW-1:0] p;

   logic          mul_load, mul_step, mul_busy;
   logic [PW-1:0] mul_mcand, mul_prod;
   logic [DW:0]   mul_mplier;

   function automatic logic [DW:0] mag_of(input logic [DW-1:0] v);
      logic [DW:0] ext;
      ext = {v[DW-1], v};
      return v[DW-1] ? ('0 - ext) : ext;
   endfunction

`ifdef PROD3_ZERO_SKIP_EN
   logic any_zero;
   assign any_zero = (mag_a == '0) || (mag_b == '0) || (mem_rd_data == '0);
`endif

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         start_q <= 1'b1;
         cnt     <= '0;
      end else begin
         state   <= next;
         start_q <= start;
         cnt     <= (state == MUL1 || state == MUL2) ? cnt + 1'b1 : '0;
      end
   end

   // ---------------- next state / outputs ----------------
   always_comb begin
      next        = state;
      done        = 1'b0;
      mem_addr    = '0;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      mul_load    = 1'b0;
      mul_step    = 1'b0;
      case (state)
         IDLE: if (!start && start_q) next = LD_A;
         LD_A: begin
            mem_addr = AW'(IN_BASE);
            next     = LD_B;
         end
         LD_B: begin
            mem_addr = AW'(IN_BASE + 1);
            next     = LD_C;
         end
         LD_C: begin
            mem_addr = AW'(IN_BASE + 2);
`ifdef PROD3_ZERO_SKIP_EN
            next     = any_zero ? ST0 : MUL1;
`else
            next     = MUL1;
`endif
         end
         MUL1, MUL2: begin
            // the multiplier idles between passes, so !busy marks a pass's first cycle
            mul_load = !mul_busy;
            mul_step = mul_busy;
            if (cnt == CW'(MUL_STEPS - 1)) next = (state == MUL1) ? MUL2 : SIGN;
         end
         SIGN: next = ST0;
         ST0: begin
            mem_wr_en   = 1'b1;
            mem_addr    = AW'(OUT_BASE);
            mem_wr_data = p[0 +: DW];
            next        = ST1;
         end
         ST1: begin
            mem_wr_en   = 1'b1;
            mem_addr    = AW'(OUT_BASE + 1);
            mem_wr_data = p[DW +: DW];
            next        = ST2;
         end
         ST2: begin
            mem_wr_en   = 1'b1;
            mem_addr    = AW'(OUT_BASE + 2);
            mem_wr_data = p[2*DW +: DW];
            next        = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   // ---------------- operand / result registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         mag_a <= '0;
         mag_b <= '0;
         mag_c <= '0;
         s_a   <= 1'b0;
         s_b   <= 1'b0;
         s_c   <= 1'b0;
         p     <= '0;
      end else begin
         case (state)
            LD_A: begin
               mag_a <= mag_of(mem_rd_data);
               s_a   <= mem_rd_data[DW-1];
            end
            LD_B: begin
               mag_b <= mag_of(mem_rd_data);
               s_b   <= mem_rd_data[DW-1];
            end
            LD_C: begin
               mag_c <= mag_of(mem_rd_data);
               s_c   <= mem_rd_data[DW-1];
`ifdef PROD3_ZERO_SKIP_EN
               if (any_zero) p <= '0;
`endif
            end
            SIGN: p <= (s_a ^ s_b ^ s_c) ? ('0 - mul_prod) : mul_prod;
            default: ;
         endcase
      end
   end

   // pass 1: |A|*|B|; pass 2: P1*|C| with P1 fed back from the accumulator
   assign mul_mcand  = (state == MUL2) ? mul_prod : PW'(mag_a);
   assign mul_mplier = (state == MUL2) ? mag_c : mag_b;

   serial_umul #(
      .MW    (PW),
      .NW    (DW + 1),
      .STEPS (MUL_STEPS)
   ) u_mul (
      .clk    (clk),
      .reset  (reset),
      .load   (mul_load),
      .step   (mul_step),
      .mcand  (mul_mcand),
      .mplier (mul_mplier),
      .busy   (mul_busy),
      .prod   (mul_prod)
   );

endmodule

// File: tb/tb_prod3_sequencer.sv
// tb_prod3_sequencer: directed bench for prod3_sequencer with a data-memory
// model and a queue of expected products.
module tb_prod3_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       done;
   logic [7:0] mem_addr;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;
   logic [7:0] mem_rd_data;

   logic [7:0]  dm [0:255];
   logic [23:0] exp_q [$];
   int          wr_total = 0;
   int          bad_wr   = 0;
   int          tests    = 0;
   int          fails    = 0;

   always #5 clk = ~clk;

   prod3_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   assign mem_rd_data = dm[mem_addr];

   // memory write port, sampled mid-cycle
   always @(negedge clk) begin
      if (mem_wr_en === 1'b1) begin
         dm[mem_addr] = mem_wr_data;
         wr_total++;
         if (mem_addr < 8'd3 || mem_addr > 8'd5) bad_wr++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
      int r;
      r = int'($signed(a)) * int'($signed(b)) * int'($signed(c));
      return r[23:0];
   endfunction

   task automatic setup(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      dm[0] = a;
      dm[1] = b;
      dm[2] = c;
      dm[3] = 8'hAA;
      dm[4] = 8'hAA;
      dm[5] = 8'hAA;
      exp_q.push_back(model(a, b, c));
   endtask

   // called at the negedge just before E0
   task automatic wait_result(input string tag, input int lat);
      int          edges;
      int          w0;
      logic [23:0] exp;
      edges = 0;
      w0    = wr_total;
      @(negedge clk);
      while (done !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_latency"}, edges, lat);
      chk({tag, "_strobes"}, wr_total - w0, 32'd3);
      exp = exp_q.pop_front();
      chk({tag, "_product"}, {8'd0, dm[5], dm[4], dm[3]}, {8'd0, exp});
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input int lat);
      setup(a, b, c);
      start = 1'b1;
      @(negedge clk);
      chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
      start = 1'b0;
      wait_result(tag, lat);
   endtask

   initial begin
      int w0;
      int zlat;
`ifdef PROD3_ZERO_SKIP_EN
      zlat = 6;
`else
      zlat = 23;
`endif
      for (int i = 0; i < 256; i++) dm[i] = 8'h00;

      reset = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_done",  {31'd0, done}, 32'd0);
      chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("rst_addr",  {24'd0, mem_addr}, 32'd0);
      chk("rst_wdata", {24'd0, mem_wr_data}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op("p_2_4_8",   8'd2,   8'd4,   8'd8,   23);
      chk("p_2_4_8_dm3", {24'd0, dm[3]}, 32'h40);
      run_op("m128_cube", 8'h80,  8'h80,  8'h80,  23);
      run_op("m3_5_7",    8'hFD,  8'd5,   8'd7,   23);

      // handshake: done holds while start stays low
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_done", {31'd0, done}, 32'd1);
      end
      run_op("p127_m1",   8'd127, 8'd127, 8'hFF,  23);

      // reset on the 4th MUL1 cycle
      dm[0] = 8'd5; dm[1] = 8'd6; dm[2] = 8'd7;
      dm[3] = 8'hAA; dm[4] = 8'hAA; dm[5] = 8'hAA;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w0 = wr_total;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_addr", {24'd0, mem_addr}, 32'd0);
      repeat (30) @(negedge clk);
      chk("abort_no_wr", wr_total - w0, 32'd0);
      chk("abort_idle_done", {31'd0, done}, 32'd0);
      chk("abort_dm3", {24'd0, dm[3]}, 32'hAA);
      run_op("one_cube",  8'd1,   8'd1,   8'd1,   23);

      run_op("zero_op",   8'd0,   8'd99,  8'hF9,  zlat);

      // reset released with start already low: run begins at that edge
      setup(8'hF6, 8'd3, 8'hFE);
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rr_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      wait_result("rst_release", 23);

      chk("stray_writes", bad_wr, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/prod3_sequencer.md
Name: prod3_sequencer

Overview:
- Hardware sequencer for the program-3 operation D = OpA * OpB * OpC.
- Operands are three 8-bit two's-complement bytes; D is a 24-bit two's-complement product.
- It owns the data-memory port while running:
  - reads the operands from dm[0..2];
  - runs two iterative unsigned shift-add multiplies on operand magnitudes;
  - writes the product little-endian to dm[3..5].
- Top-level handshake is the same as the DUT's: start/done.

Parameters:
- DW, 8, operand width.
- PW, 24, product width; must equal 3*DW.
- AW, 8, data-memory address width.
- IN_BASE, 0, address of OpA; OpB and OpC sit at IN_BASE+1 and IN_BASE+2.
- OUT_BASE, 3, address of product LSB; bytes go to OUT_BASE..OUT_BASE+2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; a falling edge initiates a run.
- done  out  1  acknowledge; high while the result is valid.
- mem_addr  out  AW  data-memory address.
- mem_wr_en  out  1  data-memory write strobe, one cycle per byte.
- mem_wr_data  out  DW  data-memory write data.
- mem_rd_data  in  DW  data-memory read data, combinational from mem_addr.

Behaviour:
- Reset (edge with reset=1):
  - state=IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0;
  - all operand and accumulator registers 0;
  - start_q=1, so a start low at the first non-reset edge counts as a falling edge.
- Reset has priority over every other event, including mid-run; no memory write occurs on a reset edge.
- Edge detect:
  - start_q registers start every edge;
  - a run begins on the IDLE edge where start=0 and start_q=1 (edge E0).
- States and transitions:
  - IDLE -> LD_A -> LD_B -> LD_C -> MUL1 (8 cycles) -> MUL2 (8 cycles) -> SIGN -> ST0 -> ST1 -> ST2 -> DONE.
  - LD_x: drive mem_addr=IN_BASE+k and capture mem_rd_data at the next edge.
  - Capture stores the magnitude as (DW+1)-bit unsigned (|-128|=128) and the sign bit.
  - MUL1: P1 = |A|*|B|, 16-bit. One multiplier bit of |B| per cycle, LSB first, shift-add.
  - MUL2: P2 = P1*|C|, truncated to PW bits. Exact, since the maximum magnitude is 2^21.
  - SIGN: if sA^sB^sC, then P = -P2 (two's complement, PW bits), else P = P2.
  - ST0, ST1, ST2: mem_wr_en=1, mem_addr=OUT_BASE+k, mem_wr_data=P[8k+7:8k].
  - DONE: done=1; mem_wr_en=0.
- DONE exit: on the edge where start=1, go to IDLE; done reads 0 after that edge.
- Latency: done=1 after the 23rd rising edge following E0 (3 load + 8 + 8 + 1 sign + 3 store). Fixed and data-independent.
- start activity during LD..ST2 is ignored; start_q keeps tracking.
- No new run starts in DONE. start must rise (exit to IDLE), then fall again.
- Only ST0..ST2 write memory; no other state asserts mem_wr_en.

Optional Feature:
- Macro: PROD3_ZERO_SKIP_EN.
- Defined:
  - In LD_C, if any captured operand (A, B, or the C being read) is zero, go directly to ST0 with P=0.
  - done then rises after the 6th edge following E0.
- Undefined: the full 23-edge path always runs; a zero operand still yields P=0.

Decomposition:
- Package prod3_pkg holds:
  - state_t enum (IDLE, LD_A, LD_B, LD_C, MUL1, MUL2, SIGN, ST0, ST1, ST2, DONE);
  - MUL_STEPS=8;
  - default address constants.
- One sub-module: serial_umul.
  - A 1-bit-per-cycle unsigned shift-add multiplier with load/step/busy.
  - It is instantiated once and time-shared between MUL1 and MUL2, with the multiplicand muxed by state.

Test Plan:
- 2, 4, 8 -> dm[3]=0x40, dm[4]=0x00, dm[5]=0x00; done high exactly 23 edges after E0; exactly 3 write strobes.
- -128, -128, -128 -> {dm5,dm4,dm3}=0xE00000 (-2097152); -3, 5, 7 -> 0xFFFF97 (-105); 127, 127, -1 -> 0xFFC0FF (-16129).
- Reset pulsed on the 4th MUL1 cycle -> no memory write, done=0, IDLE. Next fall of start with 1, 1, 1 -> 0x000001.
- Handshake: in DONE, hold start low 5 cycles -> done stays 1. Raise start -> done=0 next edge. A second run with new operands gives the correct product.
- 0, 99, -7:
  - with PROD3_ZERO_SKIP_EN -> 0x000000, done after 6 edges;
  - without -> 0x000000, done after 23 edges.
- Reset release with start already low at the same edge (start_q reset to 1) -> run begins at that edge, matching the start/reset ordering the top-level bench drives.
